// File: rtl/sad_accum.sv
// rtl/sad_accum.sv - block sum-of-absolute-differences accumulator with result handshake.
// Optional build macro SAD_ACCUM_SAT_EN: saturate the accumulator instead of wrapping.
module sad_accum #(
    parameter int N     = 8,
    parameter int SUM_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       diff,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [SUM_W-1:0] sad,
    output logic             sad_valid,
    input  logic             sad_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [SUM_W-1:0] acc, acc_nxt;
    logic [SUM_W-1:0] sad_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SUM_W-1:0] sum;
    logic             xfer;
    logic             last;

`ifdef SAD_ACCUM_SAT_EN
    // One extra bit catches the carry so the sum can clamp at all-ones.
    logic [SUM_W:0] sum_wide;
    assign sum_wide = {1'b0, acc} + {{(SUM_W - 3){1'b0}}, diff};
    assign sum      = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
`else
    assign sum = acc + {{(SUM_W - 4){1'b0}}, diff};
`endif

    assign xfer = din_valid && (state == ACC);
    assign last = (cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sad   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sad   <= sad_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sad_nxt   = sad;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACC;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            ACC: begin
                if (xfer) begin
                    acc_nxt = sum;
                    cnt_nxt = cnt + CNT_W'(1);
                    // The final sample goes straight into the result register.
                    if (last) begin
                        state_nxt = DONE;
                        sad_nxt   = sum;
                    end
                end
            end
            DONE: begin
                if (sad_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        din_ready = (state == ACC);
        sad_valid = (state == DONE);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_sad_accum.sv
// tb/tb_sad_accum.sv - scoreboard bench for sad_accum (N=4/SUM_W=7, N=4/SUM_W=5, N=1).
module tb_sad_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] diff = 4'd0;
    logic       din_valid = 1'b0;
    logic       sad_ready = 1'b0;

    logic       din_ready, sad_valid, busy;
    logic [6:0] sad;
    logic       din_ready5, sad_valid5, busy5;
    logic [4:0] sad5;
    logic       din_ready1, sad_valid1, busy1;
    logic [6:0] sad1;

    int n_checks = 0;
    int n_fail = 0;
    int exp_q[$];
    int exp;

    always #5 clk = ~clk;

    sad_accum #(.N(4), .SUM_W(7)) u_dut (
        .clk(clk), .rst(rst), .start(start), .diff(diff), .din_valid(din_valid),
        .din_ready(din_ready), .sad(sad), .sad_valid(sad_valid),
        .sad_ready(sad_ready), .busy(busy)
    );

    sad_accum #(.N(4), .SUM_W(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start), .diff(diff), .din_valid(din_valid),
        .din_ready(din_ready5), .sad(sad5), .sad_valid(sad_valid5),
        .sad_ready(sad_ready), .busy(busy5)
    );

    sad_accum #(.N(1), .SUM_W(7)) u_one (
        .clk(clk), .rst(rst), .start(start), .diff(diff), .din_valid(din_valid),
        .din_ready(din_ready1), .sad(sad1), .sad_valid(sad_valid1),
        .sad_ready(sad_ready), .busy(busy1)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; din_valid = 1'b0; sad_ready = 1'b0; diff = 4'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] d);
        @(negedge clk);
        start = 1'b0; diff = d; din_valid = 1'b1;
    endtask

    task automatic gap();
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        sad_ready = 1'b1;
        @(negedge clk);
        sad_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready got %b want 0", din_ready); end
        n_checks++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sad_valid got %b want 0", sad_valid); end
        n_checks++; if (sad !== 7'd0) begin n_fail++; $display("FAIL reset_sad got %0d want 0", sad); end
        rst = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_start busy got %b want 1", busy); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset busy got %b want 0", busy); end
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset din_ready got %b want 0", din_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_start();
        n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_din_ready got %b want 1", din_ready); end
        send(4'd3); send(4'd5); send(4'd7); send(4'd9);
        exp_q.push_back(24);
        n_checks++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid got %b want 0", sad_valid); end
        gap();
        n_checks++; if (sad_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_latency sad_valid got %b want 1", sad_valid); end
        exp = exp_q.pop_front();
        n_checks++; if (sad !== 7'(exp)) begin n_fail++; $display("FAIL b2b_sad got %0d want %0d", sad, exp); end
        handshake();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle busy got %b want 0", busy); end
        n_checks++; if (sad !== 7'd24) begin n_fail++; $display("FAIL b2b_retain sad got %0d want 24", sad); end
    endtask

    task automatic test_gaps();
        apply_reset();
        do_start();
        for (int k = 0; k < 4; k++) begin
            send(4'(k + 1));
            if (k == 3) exp_q.push_back(10);
            gap();
            if (k < 3) begin
                n_checks++; if (u_dut.cnt !== 3'(k + 1)) begin n_fail++; $display("FAIL gap_cnt got %0d want %0d", u_dut.cnt, k + 1); end
                @(negedge clk);
                n_checks++; if (u_dut.cnt !== 3'(k + 1)) begin n_fail++; $display("FAIL gap_frozen got %0d want %0d", u_dut.cnt, k + 1); end
                n_checks++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid got %b want 0", sad_valid); end
            end else begin
                n_checks++; if (sad_valid !== 1'b1) begin n_fail++; $display("FAIL gap_done_valid got %b want 1", sad_valid); end
                exp = exp_q.pop_front();
                n_checks++; if (sad !== 7'(exp)) begin n_fail++; $display("FAIL gap_sad got %0d want %0d", sad, exp); end
            end
        end
        handshake();
    endtask

    task automatic test_hold();
        apply_reset();
        do_start();
        send(4'd1); send(4'd1);
        gap();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(4'd1); send(4'd1);
        exp_q.push_back(4);
        gap();
        exp = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (sad_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid cycle %0d got %b want 1", c, sad_valid); end
            n_checks++; if (sad !== 7'(exp)) begin n_fail++; $display("FAIL hold_sad cycle %0d got %0d want %0d", c, sad, exp); end
            n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL hold_din_ready cycle %0d got %b want 0", c, din_ready); end
            start = (c == 2);
            @(negedge clk);
        end
        start = 1'b0;
        sad_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        sad_ready = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_release busy got %b want 0", busy); end
        n_checks++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release sad_valid got %b want 0", sad_valid); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_start_ignored busy got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        apply_reset();
        do_start();
        for (int k = 0; k < 4; k++) send(4'd15);
`ifdef SAD_ACCUM_SAT_EN
        exp_q.push_back(31);
`else
        exp_q.push_back(28);
`endif
        gap();
        n_checks++; if (sad_valid5 !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got %b want 1", sad_valid5); end
        exp = exp_q.pop_front();
        n_checks++; if (sad5 !== 5'(exp)) begin n_fail++; $display("FAIL ovf_sad got %0d want %0d", sad5, exp); end
        n_checks++; if (sad !== 7'd60) begin n_fail++; $display("FAIL wide_sad got %0d want 60", sad); end
        handshake();
    endtask

    task automatic test_reset_mid();
        do_start();
        send(4'd2); send(4'd2);
        @(negedge clk);
        din_valid = 1'b0; rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst busy got %b want 0", busy); end
        n_checks++; if (sad !== 7'd0) begin n_fail++; $display("FAIL mid_rst sad got %0d want 0", sad); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_quiet cycle %0d got %b want 0", c, sad_valid); end
        end
        do_start();
        for (int k = 0; k < 4; k++) begin
            send(4'd2);
            n_checks++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_early_valid k %0d got %b want 0", k, sad_valid); end
        end
        exp_q.push_back(8);
        gap();
        n_checks++; if (sad_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rst_valid got %b want 1", sad_valid); end
        exp = exp_q.pop_front();
        n_checks++; if (sad !== 7'(exp)) begin n_fail++; $display("FAIL mid_rst_sad got %0d want %0d", sad, exp); end
        handshake();
    endtask

    task automatic test_n1();
        apply_reset();
        do_start();
        send(4'd13);
        exp_q.push_back(13);
        n_checks++; if (sad_valid1 !== 1'b0) begin n_fail++; $display("FAIL n1_early_valid got %b want 0", sad_valid1); end
        gap();
        n_checks++; if (sad_valid1 !== 1'b1) begin n_fail++; $display("FAIL n1_valid got %b want 1", sad_valid1); end
        exp = exp_q.pop_front();
        n_checks++; if (sad1 !== 7'(exp)) begin n_fail++; $display("FAIL n1_sad got %0d want %0d", sad1, exp); end
        n_checks++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL n4_not_done got %b want 0", sad_valid); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_hold();
        test_overflow();
        test_reset_mid();
        test_n1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
